// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
//
// Bridges the SPI receiver, the debounced gravity clock and game_executioner.
// Incoming SPI move bytes are queued in a small FIFO. The gravity-tick level
// becomes a single coalesced pending request. One operation at a time is
// handed to the executioner through a start pulse / ready handshake. The SPI
// receiver is cleared after every capture, whether the byte was queued or
// dropped.
//
// Ports
//   clk                 system clock (HSOSC domain)
//   reset_n             asynchronous active-low reset
//   spi_data_valid      level from spi, stays high until cleared
//   spi_data[7:0]       [1:0] move, [4:2] piece select, [5] move valid,
//                       [7:6] unused
//   spi_clear           one-cycle pulse back to spi.clear
//   gravity_tick        debounced game-clock level; each rising edge is one
//                       gravity request
//   exec_ready          executioner idle
//   exec_move_start     one-cycle move start pulse
//   exec_move           move command, held until the next move issue
//   exec_move_valid     held with exec_move
//   exec_piece_sel      held with exec_move
//   exec_gravity_start  one-cycle gravity step pulse
//   fifo_count          current FIFO occupancy
//   dropped_count       saturating count of bytes lost to a full FIFO
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module move_scheduler #(
    parameter int FIFO_DEPTH        = 4,
    parameter int GRAVITY_MAX_DEFER = 3
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              spi_data_valid,
    input  logic [7:0]                        spi_data,
    output logic                              spi_clear,
    input  logic                              gravity_tick,
    input  logic                              exec_ready,
    output logic                              exec_move_start,
    output logic [1:0]                        exec_move,
    output logic                              exec_move_valid,
    output logic [2:0]                        exec_piece_sel,
    output logic                              exec_gravity_start,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic [7:0]                        dropped_count
);

    localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    // Defer counter must be able to hold GRAVITY_MAX_DEFER itself.
    localparam int DW = (GRAVITY_MAX_DEFER < 1) ? 1 : $clog2(GRAVITY_MAX_DEFER + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    // Edge detection history
    logic          spi_prev_r;
    logic          grav_prev_r;
    logic          spi_edge_s;
    logic          grav_edge_s;

    // FIFO storage and bookkeeping
    logic [5:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          push_s;
    logic          drop_s;
    logic [5:0]    head_s;

    // Gravity request tracking
    logic          grav_pending_r;
    logic [DW-1:0] defer_cnt_r;
    logic          defer_at_max_s;

    // Arbitration / FSM
    state_t        state_r;
    state_t        state_nxt_s;
    logic          issue_move_s;
    logic          issue_grav_s;

    // Output registers
    logic          clear_r;
    logic          move_start_r;
    logic          grav_start_r;
    logic [1:0]    move_r;
    logic          move_valid_r;
    logic [2:0]    piece_sel_r;
    logic [7:0]    drop_cnt_r;

    // The two top SPI bits carry nothing for this block.
    logic          unused_s;
    assign unused_s = ^spi_data[7:6];

    // Edge detects and FIFO status decode.
    always_comb begin
        spi_edge_s     = spi_data_valid & ~spi_prev_r;
        grav_edge_s    = gravity_tick & ~grav_prev_r;
        fifo_full_s    = (count_r == CW'(FIFO_DEPTH));
        fifo_empty_s   = (count_r == {CW{1'b0}});
        // Fullness is judged before any pop of this cycle, so a push into a
        // full FIFO is dropped even if the head leaves at the same edge.
        push_s         = spi_edge_s & ~fifo_full_s;
        drop_s         = spi_edge_s & fifo_full_s;
        head_s         = mem_r[rd_ptr_r];
        defer_at_max_s = (defer_cnt_r >= DW'(GRAVITY_MAX_DEFER));
    end

    // Next-state and issue selection for the executioner handshake.
    always_comb begin
        state_nxt_s  = state_r;
        issue_move_s = 1'b0;
        issue_grav_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (exec_ready) begin
                    // Gravity goes first when nothing else is waiting or
                    // when it has already been passed over often enough.
                    if (grav_pending_r && (fifo_empty_s || defer_at_max_s)) begin
                        issue_grav_s = 1'b1;
                        state_nxt_s  = ST_GUARD;
                    end else if (!fifo_empty_s) begin
                        issue_move_s = 1'b1;
                        state_nxt_s  = ST_GUARD;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GUARD: begin
                // exec_ready may still show the pre-start value here.
                state_nxt_s = ST_BUSY;
            end
            ST_BUSY: begin
                if (exec_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Input history for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_prev_r  <= 1'b0;
            grav_prev_r <= 1'b0;
        end else begin
            spi_prev_r  <= spi_data_valid;
            grav_prev_r <= gravity_tick;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 6'd0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= spi_data[5:0];
                // Depth is a power of two, so pointers wrap on overflow.
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (issue_move_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, issue_move_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Pending gravity request and the count of moves that jumped ahead of it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grav_pending_r <= 1'b0;
            defer_cnt_r    <= {DW{1'b0}};
        end else begin
            // An edge landing on the issuing cycle re-arms the request.
            grav_pending_r <= grav_edge_s | (grav_pending_r & ~issue_grav_s);
            if (issue_grav_s) begin
                defer_cnt_r <= {DW{1'b0}};
            end else if (issue_move_s && grav_pending_r) begin
                defer_cnt_r <= defer_cnt_r + DW'(1);
            end else begin
                defer_cnt_r <= defer_cnt_r;
            end
        end
    end

    // Registered handshake pulses and held move fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clear_r      <= 1'b0;
            move_start_r <= 1'b0;
            grav_start_r <= 1'b0;
            move_r       <= 2'd0;
            move_valid_r <= 1'b0;
            piece_sel_r  <= 3'd0;
        end else begin
            clear_r      <= spi_edge_s;
            move_start_r <= issue_move_s;
            grav_start_r <= issue_grav_s;
            if (issue_move_s) begin
                move_r       <= head_s[1:0];
                piece_sel_r  <= head_s[4:2];
                move_valid_r <= head_s[5];
            end
        end
    end

    // Saturating count of bytes lost to a full FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign spi_clear          = clear_r;
    assign exec_move_start    = move_start_r;
    assign exec_gravity_start = grav_start_r;
    assign exec_move          = move_r;
    assign exec_move_valid    = move_valid_r;
    assign exec_piece_sel     = piece_sel_r;
    assign fifo_count         = count_r;
    assign dropped_count      = drop_cnt_r;

endmodule

// File: tb/tb_move_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for move_scheduler. Inputs are driven on the falling edge; the
// reference model (a queue of move entries plus a pending-gravity flag and a
// handshake phase) is advanced with the same inputs, and all DUT outputs are
// compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_move_scheduler;

    localparam int DEPTH = 4;
    localparam int MAXD  = 3;

    logic       clk;
    logic       reset_n;
    logic       spi_data_valid;
    logic [7:0] spi_data;
    logic       spi_clear;
    logic       gravity_tick;
    logic       exec_ready;
    logic       exec_move_start;
    logic [1:0] exec_move;
    logic       exec_move_valid;
    logic [2:0] exec_piece_sel;
    logic       exec_gravity_start;
    logic [2:0] fifo_count;
    logic [7:0] dropped_count;

    move_scheduler #(.FIFO_DEPTH(DEPTH), .GRAVITY_MAX_DEFER(MAXD)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .spi_data_valid     (spi_data_valid),
        .spi_data           (spi_data),
        .spi_clear          (spi_clear),
        .gravity_tick       (gravity_tick),
        .exec_ready         (exec_ready),
        .exec_move_start    (exec_move_start),
        .exec_move          (exec_move),
        .exec_move_valid    (exec_move_valid),
        .exec_piece_sel     (exec_piece_sel),
        .exec_gravity_start (exec_gravity_start),
        .fifo_count         (fifo_count),
        .dropped_count      (dropped_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    int q[$];
    int m_drop;
    bit m_gpend;
    int m_defer;
    int m_phase;   // 0: may issue, 1: dead cycle after a start, 2: awaiting ready
    bit m_pspi, m_pgrav;
    bit e_clear, e_ms, e_gs;
    int e_move, e_mv, e_psel;

    // Observed issue history
    int issue_log[$];
    int ms_obs = 0;
    int gs_obs = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_drop = 0; m_gpend = 0; m_defer = 0; m_phase = 0;
        m_pspi = 0; m_pgrav = 0;
        e_clear = 0; e_ms = 0; e_gs = 0;
        e_move = 0; e_mv = 0; e_psel = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit g, input bit r);
        bit se, ge, full0;
        int ent;
        se    = v && !m_pspi;
        ge    = g && !m_pgrav;
        full0 = (q.size() == DEPTH);
        e_ms  = 0;
        e_gs  = 0;
        if (m_phase == 0) begin
            if (r && m_gpend && (q.size() == 0 || m_defer == MAXD)) begin
                e_gs = 1; m_gpend = 0; m_defer = 0; m_phase = 1;
            end else if (r && q.size() > 0) begin
                ent    = q.pop_front();
                e_move = ent % 4;
                e_psel = (ent / 4) % 8;
                e_mv   = (ent / 32) % 2;
                e_ms   = 1;
                if (m_gpend) m_defer++;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (r) begin
            m_phase = 0;
        end
        e_clear = se;
        if (se) begin
            if (full0) begin
                if (m_drop < 255) m_drop++;
            end else begin
                q.push_back(int'(d[5:0]));
            end
        end
        if (ge) m_gpend = 1;
        m_pspi  = v;
        m_pgrav = g;
    endtask

    task automatic check_outputs();
        if (exec_move_start === 1'b1) begin issue_log.push_back(1); ms_obs++; end
        if (exec_gravity_start === 1'b1) begin issue_log.push_back(2); gs_obs++; end
        check_value("spi_clear", 32'(spi_clear), 32'(e_clear));
        check_value("move_start", 32'(exec_move_start), 32'(e_ms));
        check_value("grav_start", 32'(exec_gravity_start), 32'(e_gs));
        check_value("start_excl", 32'(exec_move_start & exec_gravity_start), 32'd0);
        check_value("exec_move", 32'(exec_move), 32'(e_move));
        check_value("exec_move_valid", 32'(exec_move_valid), 32'(e_mv));
        check_value("exec_piece_sel", 32'(exec_piece_sel), 32'(e_psel));
        check_value("fifo_count", 32'(fifo_count), 32'(q.size()));
        check_value("dropped_count", 32'(dropped_count), 32'(m_drop));
    endtask

    // One clock: drive at the falling edge, model, then compare one cycle on.
    task automatic tick(input bit v, input logic [7:0] d, input bit g, input bit r);
        spi_data_valid = v;
        spi_data       = d;
        gravity_tick   = g;
        exec_ready     = r;
        model_step(v, d, g, r);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_cycles(input int n, input bit r);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, r);
    endtask

    // One SPI byte: valid high for one cycle (the clear arrives next), then low.
    task automatic spi_byte(input logic [7:0] d, input bit r);
        tick(1'b1, d, 1'b0, r);
        tick(1'b0, d, 1'b0, r);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_clear"}, 32'(spi_clear), 32'd0);
        check_value({tag, "_mstart"}, 32'(exec_move_start), 32'd0);
        check_value({tag, "_gstart"}, 32'(exec_gravity_start), 32'd0);
        check_value({tag, "_move"}, 32'({exec_move_valid, exec_piece_sel, exec_move}), 32'd0);
        check_value({tag, "_count"}, 32'(fifo_count), 32'd0);
        check_value({tag, "_drop"}, 32'(dropped_count), 32'd0);
    endtask

    initial begin
        int ms0, gs0;
        bit rv, rg;
        logic [7:0] rd;

        reset_n        = 1'b0;
        spi_data_valid = 1'b0;
        spi_data       = 8'h00;
        gravity_tick   = 1'b0;
        exec_ready     = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // 1: single byte 0x2D, executioner ready
        idle_cycles(2, 1'b1);
        tick(1'b1, 8'h2D, 1'b0, 1'b1);                     // cycle N
        check_value("t1_clear_n1", 32'(spi_clear), 32'd1);
        check_value("t1_count_n1", 32'(fifo_count), 32'd1);
        tick(1'b0, 8'h2D, 1'b0, 1'b1);                     // cycle N+1
        check_value("t1_mstart_n2", 32'(exec_move_start), 32'd1);
        check_value("t1_move", 32'(exec_move), 32'd1);
        check_value("t1_piece", 32'(exec_piece_sel), 32'd3);
        check_value("t1_valid", 32'(exec_move_valid), 32'd1);
        check_value("t1_count_n2", 32'(fifo_count), 32'd0);
        idle_cycles(4, 1'b1);

        // 2: six bytes with executioner busy -> four kept, two dropped
        for (int i = 0; i < 6; i++) spi_byte(8'(8'h20 + 8'(i * 5)), 1'b0);
        check_value("t2_count", 32'(fifo_count), 32'd4);
        check_value("t2_drop", 32'(dropped_count), 32'd2);
        issue_log.delete();
        idle_cycles(16, 1'b1);
        check_value("t2_issues", 32'(issue_log.size()), 32'd4);

        // 3: four moves queued with gravity pending
        for (int i = 0; i < 4; i++) spi_byte(8'(8'h21 + 8'(i)), 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        issue_log.delete();
        idle_cycles(20, 1'b1);
        check_value("t3_n", 32'(issue_log.size()), 32'd5);
        if (issue_log.size() == 5) begin
            check_value("t3_seq", 32'(issue_log[0] * 10000 + issue_log[1] * 1000 +
                        issue_log[2] * 100 + issue_log[3] * 10 + issue_log[4]), 32'd11121);
        end

        // 4: three gravity edges while busy coalesce into one request
        gs0 = gs_obs;
        spi_byte(8'h26, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            tick(1'b0, 8'h00, 1'b0, 1'b0);
        end
        check_value("t4_none_busy", 32'(gs_obs - gs0), 32'd0);
        idle_cycles(12, 1'b1);
        check_value("t4_one_grav", 32'(gs_obs - gs0), 32'd1);

        // 5: push into a full FIFO on the same cycle as a pop
        for (int i = 0; i < 4; i++) spi_byte(8'(8'h30 + 8'(i)), 1'b0);
        check_value("t5_full", 32'(fifo_count), 32'd4);
        tick(1'b1, 8'h3F, 1'b0, 1'b1);
        check_value("t5_count", 32'(fifo_count), 32'd3);
        check_value("t5_drop", 32'(dropped_count), 32'd3);
        check_value("t5_pop", 32'(exec_move_start), 32'd1);
        idle_cycles(16, 1'b1);

        // 6: reset during BUSY with entries queued and gravity pending
        spi_byte(8'h25, 1'b1);
        idle_cycles(2, 1'b0);
        spi_byte(8'h2A, 1'b0);
        spi_byte(8'h2B, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        spi_data_valid = 1'b0;
        gravity_tick   = 1'b0;
        exec_ready     = 1'b0;
        reset_n        = 1'b0;
        #1;
        check_all_zero("t6_reset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        ms0 = ms_obs;
        gs0 = gs_obs;
        idle_cycles(10, 1'b1);
        check_value("t6_no_start", 32'((ms_obs - ms0) + (gs_obs - gs0)), 32'd0);

        // Randomized traffic
        rv = 1'b0;
        rg = 1'b0;
        rd = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if (rv && e_clear) begin
                rv = 1'b0;
            end else if (!rv && ($urandom_range(0, 3) == 0)) begin
                rv = 1'b1;
                rd = 8'($urandom);
            end
            if ($urandom_range(0, 5) == 0) rg = ~rg;
            tick(rv, rd, rg, ($urandom_range(0, 9) < 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
